// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared async-FIFO helpers: default sizes and Gray/binary pointer conversion,
// used by both the write-side and read-side controllers.
package fifo_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_ADDRWIDTH = 4;

    // Conversions work on a fixed wide word; callers zero-extend and truncate.
    // Zero upper bits do not disturb the lower bits of either conversion.
    localparam int PTR_MAX = 32;
    typedef logic [PTR_MAX-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Upstream word handshake into the FIFO write controller.
// A word transfers on a rising clk edge where in_valid && in_ready; the master
// holds in_data stable while in_valid is high, and in_ready may drop at any time.
interface fifo_wr_ctrl_if #(
    parameter int WIDTH = fifo_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus whose bits change at most one at a time
// (e.g. a Gray pointer) crossing into the clk domain.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an async FIFO: accepts words, drives the external
// memory write port, and tracks full/fill against the synchronised read pointer.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int ADDRWIDTH    = DEF_ADDRWIDTH,
    parameter int AFULL_THRESH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_wr_ctrl_if.slave        up,
    input  logic [ADDRWIDTH:0]   rptr_gray_async,
    output logic                 w_en,
    output logic [ADDRWIDTH-1:0] waddr,
    output logic [WIDTH-1:0]     wdata,
    output logic [ADDRWIDTH:0]   wptr_gray,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDRWIDTH:0]   fill,
    output logic                 overflow
);

    localparam int PW = ADDRWIDTH + 1;
    typedef logic [PW-1:0] ptr_t;

    ptr_t wbin_q,  wbin_d;
    ptr_t wgray_q, wgray_d;
    ptr_t fill_q,  fill_d;
    ptr_t rq2, rbin, full_cmp;
    logic full_q,  full_d;
    logic afull_q, afull_d;
    logic ovf_q,   ovf_d;
    logic push;

    sync_2ff #(.W(PW)) u_rptr_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rptr_gray_async),
        .q_o (rq2)
    );

    // Pointers and flags are computed from wbin_d so a push and a read-pointer
    // advance seen in the same cycle land together in one update.
    always_comb begin
        push     = up.in_valid && !full_q && !rst;
        wbin_d   = wbin_q + ptr_t'(push);
        wgray_d  = ptr_t'(bin2gray(ptr_max_t'(wbin_d)));
        rbin     = ptr_t'(gray2bin(ptr_max_t'(rq2)));
        full_cmp = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
        full_d   = (wgray_d == full_cmp);
        fill_d   = wbin_d - rbin;
        afull_d  = (fill_d >= ptr_t'(AFULL_THRESH));
        ovf_d    = ovf_q | (up.in_valid && full_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            fill_q  <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            fill_q  <= fill_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign up.in_ready  = !full_q;
    assign w_en         = push;
    assign waddr        = wbin_q[ADDRWIDTH-1:0];
    assign wdata        = up.in_data;
    assign wptr_gray    = wgray_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign fill         = fill_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: writes are scoreboarded through an expected
// queue popped by a monitor; flags and pointers are checked against a small model.
module tb_fifo_wr_ctrl;

    localparam int WIDTH = 32;
    localparam int AW    = 4;
    localparam int PW    = AW + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [PW-1:0]     rptr_gray_async;
    logic              w_en;
    logic [AW-1:0]     waddr;
    logic [WIDTH-1:0]  wdata;
    logic [PW-1:0]     wptr_gray;
    logic              full;
    logic              almost_full;
    logic [PW-1:0]     fill;
    logic              overflow;

    fifo_wr_ctrl_if #(.WIDTH(WIDTH)) up_if ();

    fifo_wr_ctrl #(
        .WIDTH        (WIDTH),
        .ADDRWIDTH    (AW),
        .AFULL_THRESH (12)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .up              (up_if),
        .rptr_gray_async (rptr_gray_async),
        .w_en            (w_en),
        .waddr           (waddr),
        .wdata           (wdata),
        .wptr_gray       (wptr_gray),
        .full            (full),
        .almost_full     (almost_full),
        .fill            (fill),
        .overflow        (overflow)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard
    logic [AW+WIDTH-1:0] exp_q[$];
    logic [AW+WIDTH-1:0] mon_e;
    int checks = 0;
    int errors = 0;
    logic [PW-1:0] wr_m;
    logic [PW-1:0] rd_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    always @(negedge clk) begin
        if (w_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", waddr, wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr_data", {waddr, wdata}, mon_e);
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        exp_q.push_back({wr_m[AW-1:0], d});
        up_if.in_valid = 1'b1;
        up_if.in_data  = d;
        tick();
        up_if.in_valid = 1'b0;
        wr_m++;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        up_if.in_valid  = 1'b0;
        rptr_gray_async = '0;
        idle(2);
        rst  = 1'b0;
        wr_m = '0;
        rd_m = '0;
        tick();
    endtask

    // Directed stimulus
    initial begin
        int n;
        rst             = 1'b1;
        up_if.in_valid  = 1'b0;
        up_if.in_data   = '0;
        rptr_gray_async = '0;
        wr_m            = '0;
        rd_m            = '0;
        idle(2);
        rst = 1'b0;
        tick();

        check("reset_fill", fill, 0);
        check("reset_full", full, 0);
        check("reset_afull", almost_full, 0);
        check("reset_overflow", overflow, 0);
        check("reset_wptr_gray", wptr_gray, 0);
        check("reset_in_ready", up_if.in_ready, 1);
        check("reset_w_en", w_en, 0);

        // Reset asserted mid-burst with wbin=5
        for (int i = 0; i < 5; i++) push_word(32'hA000 + i);
        check("burst_wptr_gray", wptr_gray, 5'b00111);
        check("burst_fill", fill, 5);
        up_if.in_valid = 1'b1;
        up_if.in_data  = 32'hBAD0;
        rst            = 1'b1;
        #1;
        check("midrst_w_en", w_en, 0);
        check("midrst_in_ready", up_if.in_ready, 1);
        check("midrst_waddr", waddr, 0);
        check("midrst_wptr_gray", wptr_gray, 0);
        check("midrst_fill", fill, 0);
        check("midrst_full", full, 0);
        check("midrst_afull", almost_full, 0);
        check("midrst_overflow", overflow, 0);
        up_if.in_valid = 1'b0;
        tick();
        rst  = 1'b0;
        wr_m = '0;
        tick();

        // Fill to full
        for (int i = 0; i < 16; i++) begin
            push_word(i);
            check("fill_afull", almost_full, (i + 1 >= 12));
            check("fill_full", full, (i + 1 == 16));
        end
        check("full_fill", fill, 16);
        check("full_wptr_gray", wptr_gray, 5'b11000);
        check("full_in_ready", up_if.in_ready, 0);

        // Overflow attempts while full
        up_if.in_valid = 1'b1;
        up_if.in_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ovf_w_en", w_en, 0);
            tick();
            check("ovf_flag", overflow, 1);
        end
        up_if.in_valid = 1'b0;
        tick();
        check("ovf_sticky", overflow, 1);
        check("ovf_wptr_gray", wptr_gray, 5'b11000);
        check("ovf_fill", fill, 16);

        // Release one slot from the read side
        rptr_gray_async = 5'b00001;
        rd_m = 5'd1;
        n = 0;
        while (full === 1'b1 && n < 3) begin
            tick();
            n++;
        end
        check("release_full", full, 0);
        check("release_fill", fill, 15);
        check("release_in_ready", up_if.in_ready, 1);
        push_word(32'h1234_5678);
        check("refill_full", full, 1);
        check("refill_fill", fill, 16);
        check("still_overflow", overflow, 1);

        // Wrap-around with the level held low
        do_reset();
        for (int i = 0; i < 40; i++) begin
            push_word(32'hC000_0000 | i);
            check("wrap_full", full, 0);
            check("wrap_wptr_gray", wptr_gray, gray(wr_m));
            check("wrap_fill_conservative", (fill >= PW'(wr_m - rd_m)), 1);
            if (PW'(wr_m - rd_m) >= 6) begin
                rd_m = rd_m + 5'd2;
                rptr_gray_async = gray(rd_m);
            end
        end
        idle(3);
        check("wrap_fill_settled", fill, PW'(wr_m - rd_m));
        check("wrap_full_settled", full, 0);

        // Simultaneous push and read-pointer advance at fill=10
        do_reset();
        for (int i = 0; i < 10; i++) push_word(32'h5000 + i);
        idle(3);
        check("simul_fill_before", fill, 10);
        check("simul_afull_before", almost_full, 0);
        rd_m = 5'd1;
        rptr_gray_async = gray(rd_m);
        push_word(32'h5555_AAAA);
        check("simul_afull_during", almost_full, 0);
        idle(3);
        check("simul_fill_after", fill, 10);
        check("simul_afull_after", almost_full, 0);

        idle(2);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
